// File: rtl/reg_file_sb_if.sv
// +-----------------------------------------------------------------------+
// | reg_file_sb_if : read/writeback/issue bus of the scoreboarded regfile |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
);
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss;
  logic [AW-1:0]       ia;
  logic                flush;

  modport master (
    output ra, we, wa, wd, iss, ia, flush,
    input  rd, rbusy
  );

  modport slave (
    input  ra, we, wa, wd, iss, ia, flush,
    output rd, rbusy
  );
endinterface

`default_nettype wire

// File: rtl/reg_file_sb.sv
// +-----------------------------------------------------------------------+
// | reg_file_sb : register file with per-register busy scoreboard;        |
// | REG_FILE_SB_BYPASS_EN adds a same-cycle writeback bypass. Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [NREGS-1:0]    busy_q;
  logic [NREGS-1:0]    busy_d;
  logic                w_wr_en;
  logic [NRD*XLEN-1:0] w_rd;
  logic [NRD-1:0]      w_rbusy;

  assign w_wr_en = bus.we && (bus.wa != '0);

  // Issue is applied last so it wins over both flush and a same-register writeback.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end
    if (bus.we) begin
      busy_d[bus.wa] = 1'b0;
    end
    if (bus.iss && (bus.ia != '0)) begin
      busy_d[bus.ia] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (w_wr_en) begin
        mem_q[bus.wa] <= bus.wd;
      end
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_mem;

    assign w_addr = bus.ra[p*AW +: AW];
    assign w_mem  = (w_addr == '0) ? '0 : mem_q[w_addr];

`ifdef REG_FILE_SB_BYPASS_EN
    logic w_hit;
    assign w_hit = w_wr_en && (w_addr == bus.wa);
    assign w_rd[p*XLEN +: XLEN] = w_hit ? bus.wd : w_mem;
    assign w_rbusy[p] = w_hit ? (bus.iss && (bus.ia == bus.wa)) : busy_q[w_addr];
`else
    assign w_rd[p*XLEN +: XLEN] = w_mem;
    assign w_rbusy[p] = busy_q[w_addr];
`endif
  end

  assign bus.rd    = w_rd;
  assign bus.rbusy = w_rbusy;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// +-----------------------------------------------------------------------+
// | tb_reg_file_sb : directed self-checking bench for reg_file_sb         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) bus ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.iss = 1'b0; bus.ia = '0; bus.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    bus.ra = {a1, a0};
    #1;
  endtask

  task automatic chk_rd(input string name, input int p, input logic [XLEN-1:0] exp);
    checks++;
    if (bus.rd[p*XLEN +: XLEN] !== exp) begin
      errors++;
      $display("FAIL %s: rd[%0d]=%h expected %h", name, p, bus.rd[p*XLEN +: XLEN], exp);
    end
  endtask

  task automatic chk_busy(input string name, input logic [NRD-1:0] exp);
    checks++;
    if (bus.rbusy !== exp) begin
      errors++;
      $display("FAIL %s: rbusy=%b expected %b", name, bus.rbusy, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.we = 1'b1; bus.wa = a; bus.wd = d;
    step();
    idle();
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.iss = 1'b1; bus.ia = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    set_ra(5'd5, 5'd0);
    chk_rd("reset_rd0", 0, 32'h0);
    chk_rd("reset_rd1", 1, 32'h0);
    chk_busy("reset_busy", 2'b00);
  endtask

  task automatic test_write_read();
    set_ra(5'd0, 5'd7);
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hDEADBEEF;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk_rd("wr_same_cycle", 0, 32'hDEADBEEF);
`else
    chk_rd("wr_same_cycle", 0, 32'h0);
`endif
    step();
    idle();
    #1;
    chk_rd("wr_next_cycle", 0, 32'hDEADBEEF);
    chk_busy("wr_not_busy", 2'b00);
  endtask

  task automatic test_reg0();
    wr(5'd0, 32'hFFFFFFFF);
    set_ra(5'd0, 5'd7);
    chk_rd("reg0_rd1", 1, 32'h0);
    issue(5'd0);
    set_ra(5'd0, 5'd0);
    chk_busy("reg0_busy", 2'b00);
  endtask

  task automatic test_collision();
    issue(5'd3);
    set_ra(5'd0, 5'd3);
    chk_busy("coll_issue", 2'b01);
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h11111111;
    bus.iss = 1'b1; bus.ia = 5'd3;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    chk_rd("coll_bypass_rd", 0, 32'h11111111);
`endif
    chk_busy("coll_same_cycle", 2'b01);
    step();
    idle();
    #1;
    chk_busy("coll_stays_busy", 2'b01);
    chk_rd("coll_data1", 0, 32'h11111111);
    wr(5'd3, 32'h22222222);
    chk_busy("coll_cleared", 2'b00);
    chk_rd("coll_data2", 0, 32'h22222222);
  endtask

  task automatic test_flush_issue();
    wr(5'd4, 32'h000000A4);
    wr(5'd9, 32'h00000099);
    issue(5'd4);
    issue(5'd9);
    set_ra(5'd9, 5'd4);
    chk_busy("flush_pre", 2'b11);
    bus.flush = 1'b1; bus.iss = 1'b1; bus.ia = 5'd9;
    step();
    idle();
    #1;
    chk_busy("flush_iss", 2'b10);
    chk_rd("flush_data4", 0, 32'h000000A4);
    chk_rd("flush_data9", 1, 32'h00000099);
    bus.flush = 1'b1; bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h00000044;
    step();
    idle();
    #1;
    chk_rd("flush_write", 0, 32'h00000044);
    chk_busy("flush_clear_all", 2'b00);
  endtask

  task automatic test_back_to_back();
    issue(5'd5);
    set_ra(5'd5, 5'd5);
    chk_busy("b2b_both_ports", 2'b11);
    bus.iss = 1'b1; bus.ia = 5'd10;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h00000055;
    step();
    idle();
    set_ra(5'd10, 5'd5);
    chk_busy("b2b_diff_regs", 2'b10);
    chk_rd("b2b_data5", 0, 32'h00000055);
    set_ra(5'd5, 5'd5);
    chk_rd("b2b_port1_same", 1, 32'h00000055);
    wr(5'd5, 32'h00000056);
    chk_rd("b2b_nonbusy_wr", 0, 32'h00000056);
    chk_busy("b2b_nonbusy_busy", 2'b00);
  endtask

  task automatic test_reset_priority();
    wr(5'd2, 32'h00000077);
    rst = 1'b1;
    bus.we = 1'b1; bus.wa = 5'd2; bus.wd = 32'h5;
    bus.iss = 1'b1; bus.ia = 5'd2; bus.flush = 1'b1;
    step();
    rst = 1'b0;
    idle();
    set_ra(5'd7, 5'd2);
    chk_rd("rstp_reg2", 0, 32'h0);
    chk_busy("rstp_busy", 2'b00);
    chk_rd("rstp_reg7", 1, 32'h0);
    set_ra(5'd10, 5'd10);
    chk_busy("rstp_busy10", 2'b00);
  endtask

  initial begin
    idle();
    bus.ra = '0;
    test_reset();
    test_write_read();
    test_reg0();
    test_collision();
    test_flush_issue();
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers, a power of two, at least 2.
REQ-003 Parameter NRD, default 2: number of read ports, at least 1.
REQ-004 Parameter AW, default $clog2(NREGS): address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 ra  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
REQ-008 rd  out  NRD*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
REQ-009 rbusy  out  NRD  per read port: the addressed register has a pending write.
REQ-010 we  in  1  writeback enable.
REQ-011 wa  in  AW  writeback address.
REQ-012 wd  in  XLEN  writeback data.
REQ-013 iss  in  1  issue strobe: an instruction claims destination ia.
REQ-014 ia  in  AW  issue destination address.
REQ-015 flush  in  1  clears all pending (busy) bits; register data is kept.

Function
REQ-016 Register 0 SHALL read as zero, ignore writes, and never be busy.
REQ-017 rd and rbusy SHALL be combinational functions of ra and the current state; read latency is 0 cycles.
REQ-018 When we=1 and wa!=0, mem[wa] SHALL take wd at the rising edge, so the value is visible the next cycle.
REQ-019 Each register other than register 0 SHALL hold a busy bit.
REQ-020 When iss=1 and ia!=0, busy[ia] SHALL be set at the edge.
REQ-021 When we=1, busy[wa] SHALL be cleared at the edge.
REQ-022 If iss and we target the same nonzero register in the same cycle, busy SHALL end set, because the newer producer wins.
REQ-023 Issue and writeback to different registers in the same cycle SHALL both take effect.
REQ-024 When flush=1, all busy bits SHALL be cleared.
REQ-025 If iss=1 in the same cycle as flush, busy[ia] SHALL still end set, because the issue is post-flush.
REQ-026 flush SHALL NOT alter register contents or block a concurrent write.
REQ-027 Read ports SHALL be independent; all NRD ports addressing the same register SHALL return identical rd and rbusy.
REQ-028 A write to an already non-busy register SHALL update the data and leave busy clear.
REQ-029 No internal state is undefined after reset, and X on ra SHALL NOT corrupt state.

Reset
REQ-030 With rst=1 at an edge, all registers SHALL become 0 and all busy bits SHALL become 0.
REQ-031 rst SHALL have priority over we, iss and flush in the same cycle.
REQ-032 After reset, every rd lane SHALL read 0 and every rbusy bit SHALL read 0 until the first write or issue.
REQ-033 Reset asserted mid-operation SHALL discard pending state with no partial update.

Configuration
REQ-034 Macro REG_FILE_SB_BYPASS_EN, when defined, SHALL add a same-cycle bypass path.
- Condition: we=1, wa!=0 and ra[p]==wa.
- Effect: rd[p] returns wd and rbusy[p] returns 0, unless iss=1 and ia==wa, in which case rbusy[p] returns 1.
REQ-035 Without REG_FILE_SB_BYPASS_EN, rd and rbusy SHALL reflect only registered state, and the written value appears one cycle later.

Verification
REQ-036 Reset then read: rst=1 for 1 cycle, then ra={5,0} -> rd={0,0} and rbusy=0.
REQ-037 Write and read back: we=1, wa=7, wd=32'hDEADBEEF, ra[0]=7.
- With the macro: same-cycle rd[0]=DEADBEEF.
- Without the macro: rd[0]=0 in that cycle and DEADBEEF the next cycle.
REQ-038 Register 0 immunity: we=1, wa=0, wd=32'hFFFFFFFF, then ra[1]=0 -> rd[1]=0; iss=1, ia=0 -> rbusy stays 0.
REQ-039 Scoreboard collision:
- Cycle 1: iss=1, ia=3 -> next cycle rbusy for register 3 is 1.
- Cycle 2: we=1, wa=3, iss=1, ia=3 -> busy[3] stays 1.
- Cycle 3: we=1, wa=3 alone -> busy[3] becomes 0 and rd shows the last wd.
REQ-040 Flush with issue:
- Set busy on registers 4 and 9.
- Then flush=1 with iss=1, ia=9 -> busy[4]=0, busy[9]=1, and register data is unchanged.
REQ-041 Reset priority: rst=1 together with we=1, wa=2, wd=5 and iss=1, ia=2 -> register 2 = 0 and busy[2] = 0 next cycle.
